wb_arbiter: RTL

- Writer-side front end for the register file's single write port.
- Accepts results from two producers: the ALU, which is unbuffered, and the memory/load unit, which is buffered in a FIFO. Both use valid/ready handshakes.
- Arbitrates between them and drives a registered write enable, write index and write data into the register file.
- Exports a pending-write lookup for issue-stage stall logic.

---
 rtl/wb_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: unbuffered ALU results versus a small
// FIFO of memory results, with a starvation guard and pending-write lookup.
module wb_arbiter #(
  parameter int REGISTER_WIDTH  = 32,
  parameter int REG_INDEX_WIDTH = 5,
  parameter int FIFO_DEPTH      = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [REG_INDEX_WIDTH-1:0] alu_index,
  input  logic [REGISTER_WIDTH-1:0]  alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [REG_INDEX_WIDTH-1:0] mem_index,
  input  logic [REGISTER_WIDTH-1:0]  mem_data,
  output logic                       wr_en,
  output logic [REG_INDEX_WIDTH-1:0] wr_reg_index,
  output logic [REGISTER_WIDTH-1:0]  wr_reg_data,
  input  logic [REG_INDEX_WIDTH-1:0] chk_index,
  output logic                       chk_pending,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic [REG_INDEX_WIDTH-1:0] idx_mem  [FIFO_DEPTH];
  logic [REGISTER_WIDTH-1:0]  data_mem [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic full;
  logic nonempty;
  logic starved;
  logic fifo_win;
  logic alu_win;
  logic push;
  logic pop;
  logic hit;
  logic [PW-1:0] off;

  always_comb begin
    full     = (count == FULL_CNT);
    nonempty = (count != '0);
    starved  = (starve_cnt == SLIM);
    fifo_win = nonempty && (!alu_valid || starved);
    alu_win  = alu_valid && !fifo_win;
    push     = !rst && mem_valid && !full;
    pop      = !rst && fifo_win;
  end

  assign alu_ready  = !rst && alu_win;
  assign mem_ready  = !rst && !full;
  assign fifo_count = count;

  // Storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_ptr]  <= mem_index;
      data_mem[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pop) begin
      starve_cnt <= '0;
    end else if (alu_win && nonempty && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en        <= 1'b0;
      wr_reg_index <= '0;
      wr_reg_data  <= '0;
    end else begin
      unique case (1'b1)
        alu_win: begin
          wr_en        <= (alu_index != '0);
          wr_reg_index <= alu_index;
          wr_reg_data  <= alu_data;
        end
        fifo_win: begin
          wr_en        <= (idx_mem[rd_ptr] != '0);
          wr_reg_index <= idx_mem[rd_ptr];
          wr_reg_data  <= data_mem[rd_ptr];
        end
        default: wr_en <= 1'b0;
      endcase
    end
  end

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (({1'b0, off} < count) && (idx_mem[i] == chk_index)) hit = 1'b1;
    end
    chk_pending = (chk_index != '0) &&
                  (hit || (wr_en && (wr_reg_index == chk_index)));
  end

endmodule
